// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin front end for an APB master: arbitrates req0/req1,
// issues one transfer at a time, and aborts a transfer that waits too long.
module apb_master_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 256,
    parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
    input  logic        PCLK,
    input  logic        PRESET,

    input  logic        req0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        write0,
    output logic        done0,
    output logic [31:0] rdata0,
    output logic        err0,

    input  logic        req1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic        write1,
    output logic        done1,
    output logic [31:0] rdata1,
    output logic        err1,

    output logic        transfer,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    output logic        write,
    input  logic        ready,
    input  logic [31:0] rdata,

    output logic [1:0]  grant,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state;
    logic        last_grant;   // 0 = requester 0 served last, 1 = requester 1
    logic [15:0] wait_cnt;
    logic        pick1;
    logic        finish;

    // On a tie the requester that was not served last wins.
    always_comb begin
        pick1 = req1 && (!req0 || !last_grant);
    end

    // Ready wins over an expiring counter in the same cycle.
    always_comb begin
        finish = ready || (wait_cnt == WAIT_LAST);
    end

    assign state_dbg = state;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            wait_cnt   <= 16'd0;
            transfer   <= 1'b0;
            addr       <= 32'd0;
            wdata      <= 32'd0;
            write      <= 1'b0;
            grant      <= 2'b00;
            busy       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            rdata0     <= 32'd0;
            rdata1     <= 32'd0;
        end else begin
            transfer <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            err0     <= 1'b0;
            err1     <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        state    <= ST_ISSUE;
                        transfer <= 1'b1;
                        busy     <= 1'b1;
                        grant    <= pick1 ? 2'b10 : 2'b01;
                        addr     <= pick1 ? addr1  : addr0;
                        wdata    <= pick1 ? wdata1 : wdata0;
                        write    <= pick1 ? write1 : write0;
                    end
                end

                ST_ISSUE: begin
                    state    <= ST_WAIT;
                    wait_cnt <= 16'd0;
                end

                ST_WAIT: begin
                    if (finish) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        grant      <= 2'b00;
                        last_grant <= grant[1];
                        if (grant[1]) begin
                            done1 <= 1'b1;
                            err1  <= !ready;
                            if (!write) rdata1 <= ready ? rdata : ERR_RDATA;
                        end else begin
                            done0 <= 1'b1;
                            err0  <= !ready;
                            if (!write) rdata0 <= ready ? rdata : ERR_RDATA;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    grant <= 2'b00;
                end
            endcase
        end
    end

    // Structural invariants of the completion and issue outputs.
    a_single_done: assert property (@(posedge PCLK) disable iff (PRESET) !(done0 && done1));
    a_transfer_in_issue: assert property (@(posedge PCLK) disable iff (PRESET)
        transfer == (state == ST_ISSUE));

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYC, default 256, giving the WAIT-state cycles allowed before a transfer is aborted (legal range 2..65535).
REQ-002 The module SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF, giving the rdata returned on timeout.
REQ-003 The module SHALL have one clock; reset is synchronous and active-high.
REQ-004 PCLK  input  1  clock; all state updates on its rising edge.
REQ-005 PRESET  input  1  synchronous active-high reset.
REQ-006 req0 / req1  input  1  requester 0 (CPU data port) / requester 1 (DMA) transfer request, level, held until the matching done pulse.
REQ-007 addr0 / addr1  input  32  requester address, stable while req is high.
REQ-008 wdata0 / wdata1  input  32  requester write data, stable while req is high.
REQ-009 write0 / write1  input  1  1 = write, 0 = read.
REQ-010 done0 / done1  output  1  one-cycle completion pulse to the requester.
REQ-011 rdata0 / rdata1  output  32  read data, valid in the done cycle and held until that requester's next done.
REQ-012 err0 / err1  output  1  timeout flag, valid in the done cycle only.
REQ-013 transfer  output  1  one-cycle trigger to the APB_Master internal interface.
REQ-014 addr / wdata  output  32  latched address / write data to APB_Master.
REQ-015 write  output  1  latched direction to APB_Master.
REQ-016 ready  input  1  APB_Master completion.
REQ-017 rdata  input  32  APB_Master read data, valid when ready=1.
REQ-018 grant  output  2  one-hot current owner (bit0 = req0, bit1 = req1); 00 in IDLE.
REQ-019 busy  output  1  1 in ISSUE or WAIT.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-021 IDLE: no request -> stay in IDLE; one request -> grant that requester; both requesting -> grant the requester not granted last (round-robin via a last_grant register).
REQ-022 On the IDLE->ISSUE edge, the FSM SHALL latch the granted requester's addr/wdata/write into addr/wdata/write and set grant.
REQ-023 ISSUE SHALL last exactly one cycle with transfer=1, then go to WAIT; transfer SHALL be 0 in every other state.
REQ-024 addr/wdata/write/grant SHALL be held constant through ISSUE and WAIT.
REQ-025 ready SHALL be sampled only in WAIT; ready in IDLE or ISSUE SHALL be ignored.
REQ-026 WAIT with ready=1 on a rising edge SHALL:
  - register rdata into rdataN (reads only; writes leave rdataN unchanged);
  - pulse doneN=1 for the next cycle with errN=0;
  - update last_grant;
  - return to IDLE.
REQ-027 A 16-bit wait counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-028 If the counter reaches TIMEOUT_CYC-1 with ready=0, the FSM SHALL go to IDLE, pulse doneN=1 and errN=1, and load rdataN=ERR_RDATA for reads.
REQ-029 If ready=1 on the timeout cycle, ready SHALL win (normal completion, errN=0).
REQ-030 Latency: request seen in IDLE at edge k -> transfer high during cycle k+1 -> done high during the cycle after the edge where ready is sampled.
REQ-031 A requester deasserting req after grant SHALL NOT abort the transfer; done is still pulsed.
REQ-032 A new grant SHALL NOT occur in the done cycle itself: the FSM is in IDLE that cycle and re-arbitrates on the following edge, giving a minimum 1-cycle IDLE gap between transfers.
REQ-033 A requester SHALL be able to hold req high through its done pulse; if the other requester is waiting, round-robin SHALL grant the other.
REQ-034 done0 and done1 SHALL never be high in the same cycle.

Reset
REQ-035 PRESET=1 SHALL force state=IDLE, transfer=0, done0/1=0, err0/1=0, grant=00, busy=0, addr/wdata=0, write=0, rdata0/1=0, counter=0, and last_grant=requester 1 (so requester 0 wins the first tie).
REQ-036 Reset asserted mid-ISSUE or mid-WAIT SHALL abort silently: no done pulse, and a late ready after reset SHALL be ignored.

Verification
REQ-037 Single read: req0, addr0=0x1000_2000, write0=0; ready with rdata=0x0000_00A5 two cycles after transfer -> done0 1 cycle, rdata0=0x0000_00A5, err0=0, grant=01 during the transfer.
REQ-038 Tie: req0 and req1 asserted in the same cycle after reset -> req0 served first, then req1; with both held for four transfers, grant order is 01,10,01,10.
REQ-039 Timeout: TIMEOUT_CYC=8, read from req1, ready never asserted -> done1 with err1=1 and rdata1=0xDEAD_BEEF exactly 8 WAIT cycles after entering WAIT.
REQ-040 Write from req1, addr1=0x1000_3000, wdata1=0x0000_0055: addr/wdata/write stable from ISSUE until ready; rdata1 unchanged after done1.
REQ-041 Reset on the 3rd WAIT cycle, then ready=1 -> no done pulse, state IDLE, all outputs at reset values.
REQ-042 Coincidence: ready=1 on the timeout cycle -> err=0 and rdata taken from the bus.
